// File: rtl/distance_run_controller.sv
// rtl/distance_run_controller.sv - HUD remaining-distance countdown sequencer
module distance_run_controller #(
    parameter int FRAMES_PER_STEP = 40,
    parameter int START_DISTANCE  = 200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_v_sync,
    input  logic       i_start,
    input  logic       i_restart,
    input  logic       i_is_dead,
    output logic [3:0] o_hundreds,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_running,
    output logic       o_is_finished,
    output logic       o_finish_pulse
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Reload value split into BCD digits at elaboration time
    localparam logic [3:0] RELOAD_H = 4'((START_DISTANCE / 100) % 10);
    localparam logic [3:0] RELOAD_T = 4'((START_DISTANCE / 10) % 10);
    localparam logic [3:0] RELOAD_U = 4'(START_DISTANCE % 10);

    localparam logic [7:0] PRESCALE_LAST = 8'(FRAMES_PER_STEP - 1);

    logic [1:0] state;
    logic [7:0] prescaler;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
    logic       finish_pulse;

    logic       vs_sync1;
    logic       vs_sync2;
    logic       vs_delay;
    logic       frame_tick;

    logic [3:0] dec_hundreds;
    logic [3:0] dec_tens;
    logic [3:0] dec_units;
    logic       dec_reaches_zero;
    logic       digits_zero;

    // Bring the asynchronous v_sync into i_clk and keep one extra stage for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_sync1 <= 1'b0;
            vs_sync2 <= 1'b0;
            vs_delay <= 1'b0;
        end else begin
            vs_sync1 <= i_v_sync;
            vs_sync2 <= vs_sync1;
            vs_delay <= vs_sync2;
        end
    end

    assign frame_tick = vs_sync2 & ~vs_delay;

    assign digits_zero      = (hundreds == 4'd0) && (tens == 4'd0) && (units == 4'd0);
    assign dec_reaches_zero = (hundreds == 4'd0) && (tens == 4'd0) && (units == 4'd1);

    // Single-step BCD decrement with borrow; saturates at 000 so digits never wrap
    always_comb begin
        dec_hundreds = hundreds;
        dec_tens     = tens;
        dec_units    = units;
        if (units != 4'd0) begin
            dec_units = units - 4'd1;
        end else if (tens != 4'd0) begin
            dec_tens  = tens - 4'd1;
            dec_units = 4'd9;
        end else if (hundreds != 4'd0) begin
            dec_hundreds = hundreds - 4'd1;
            dec_tens     = 4'd9;
            dec_units    = 4'd9;
        end
    end

    // Run/halt/finish sequencing; restart outranks death, which outranks a frame step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            prescaler    <= 8'd0;
            hundreds     <= RELOAD_H;
            tens         <= RELOAD_T;
            units        <= RELOAD_U;
            finish_pulse <= 1'b0;
        end else begin
            finish_pulse <= 1'b0;
            if (i_restart) begin
                state     <= ST_IDLE;
                prescaler <= 8'd0;
                hundreds  <= RELOAD_H;
                tens      <= RELOAD_T;
                units     <= RELOAD_U;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start) begin
                            prescaler <= 8'd0;
                            if (digits_zero) begin
                                state        <= ST_DONE;
                                finish_pulse <= 1'b1;
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (i_is_dead) begin
                            state <= ST_HALT;
                        end else if (frame_tick) begin
                            if (prescaler == PRESCALE_LAST) begin
                                prescaler <= 8'd0;
                                hundreds  <= dec_hundreds;
                                tens      <= dec_tens;
                                units     <= dec_units;
                                if (dec_reaches_zero) begin
                                    state        <= ST_DONE;
                                    finish_pulse <= 1'b1;
                                end
                            end else begin
                                prescaler <= prescaler + 8'd1;
                            end
                        end
                    end
                    ST_HALT: begin
                        state <= ST_HALT;
                    end
                    default: begin
                        hundreds <= 4'd0;
                        tens     <= 4'd0;
                        units    <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign o_hundreds     = hundreds;
    assign o_tens         = tens;
    assign o_units        = units;
    assign o_running      = (state == ST_RUN);
    assign o_is_finished  = (state == ST_DONE);
    assign o_finish_pulse = finish_pulse;

endmodule

// File: tb/tb_distance_run_controller.sv
// tb/tb_distance_run_controller.sv - directed bench for distance_run_controller
module tb_distance_run_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_sync = 1'b0;
    logic [4:0] start = '0;
    logic [4:0] restart = '0;
    logic [4:0] dead = '0;

    logic [3:0] hun [5];
    logic [3:0] ten [5];
    logic [3:0] uni [5];
    logic       run [5];
    logic       fin [5];
    logic       fp  [5];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // 0: default 200/40   1: 2/1   2: 200/1   3: 0/40   4: 999/1
    distance_run_controller #(.FRAMES_PER_STEP(40), .START_DISTANCE(200)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start[0]), .i_restart(restart[0]),
        .i_is_dead(dead[0]), .o_hundreds(hun[0]), .o_tens(ten[0]), .o_units(uni[0]),
        .o_running(run[0]), .o_is_finished(fin[0]), .o_finish_pulse(fp[0]));
    distance_run_controller #(.FRAMES_PER_STEP(1), .START_DISTANCE(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start[1]), .i_restart(restart[1]),
        .i_is_dead(dead[1]), .o_hundreds(hun[1]), .o_tens(ten[1]), .o_units(uni[1]),
        .o_running(run[1]), .o_is_finished(fin[1]), .o_finish_pulse(fp[1]));
    distance_run_controller #(.FRAMES_PER_STEP(1), .START_DISTANCE(200)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start[2]), .i_restart(restart[2]),
        .i_is_dead(dead[2]), .o_hundreds(hun[2]), .o_tens(ten[2]), .o_units(uni[2]),
        .o_running(run[2]), .o_is_finished(fin[2]), .o_finish_pulse(fp[2]));
    distance_run_controller #(.FRAMES_PER_STEP(40), .START_DISTANCE(0)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start[3]), .i_restart(restart[3]),
        .i_is_dead(dead[3]), .o_hundreds(hun[3]), .o_tens(ten[3]), .o_units(uni[3]),
        .o_running(run[3]), .o_is_finished(fin[3]), .o_finish_pulse(fp[3]));
    distance_run_controller #(.FRAMES_PER_STEP(1), .START_DISTANCE(999)) u_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_v_sync(v_sync), .i_start(start[4]), .i_restart(restart[4]),
        .i_is_dead(dead[4]), .o_hundreds(hun[4]), .o_tens(ten[4]), .o_units(uni[4]),
        .o_running(run[4]), .o_is_finished(fin[4]), .o_finish_pulse(fp[4]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the cycle where the DUT frame tick is active
    task automatic vs_rise();
        v_sync = 1'b1;
        step();
        step();
    endtask

    task automatic vs_fall();
        v_sync = 1'b0;
        step();
        step();
    endtask

    task automatic tick();
        vs_rise();
        step();
        vs_fall();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic pulse_restart(input int i);
        restart[i] = 1'b1;
        step();
        restart[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step(); step();
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h200) begin n_fail++; $display("FAIL reset_digits: got %h expected 200", {hun[0], ten[0], uni[0]}); end
        n_checks++; if (run[0] !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", run[0]); end
        n_checks++; if (fin[0] !== 1'b0) begin n_fail++; $display("FAIL reset_finished: got %b expected 0", fin[0]); end
        n_checks++; if (fp[0] !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b expected 0", fp[0]); end
        n_checks++; if ({hun[4], ten[4], uni[4]} !== 12'h999) begin n_fail++; $display("FAIL reset_digits_999: got %h expected 999", {hun[4], ten[4], uni[4]}); end
        rst_n = 1'b1;
        step();
        ticks(3);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h200) begin n_fail++; $display("FAIL idle_ticks_digits: got %h expected 200", {hun[0], ten[0], uni[0]}); end
        n_checks++; if (run[0] !== 1'b0) begin n_fail++; $display("FAIL idle_ticks_running: got %b expected 0", run[0]); end
    endtask

    task automatic test_countdown();
        pulse_start(0);
        n_checks++; if (run[0] !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b expected 1", run[0]); end
        ticks(39);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h200) begin n_fail++; $display("FAIL tick39_digits: got %h expected 200", {hun[0], ten[0], uni[0]}); end
        tick();
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h199) begin n_fail++; $display("FAIL tick40_digits: got %h expected 199", {hun[0], ten[0], uni[0]}); end
        ticks(20);
        pulse_start(0);
        n_checks++; if (run[0] !== 1'b1) begin n_fail++; $display("FAIL start_in_run_running: got %b expected 1", run[0]); end
        ticks(19);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h199) begin n_fail++; $display("FAIL start_in_run_no_early_step: got %h expected 199", {hun[0], ten[0], uni[0]}); end
        tick();
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h198) begin n_fail++; $display("FAIL start_in_run_prescaler_kept: got %h expected 198", {hun[0], ten[0], uni[0]}); end
        ticks(400);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h188) begin n_fail++; $display("FAIL tick480_digits: got %h expected 188", {hun[0], ten[0], uni[0]}); end
    endtask

    task automatic test_halt();
        ticks(1559);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h150) begin n_fail++; $display("FAIL pre_halt_digits: got %h expected 150", {hun[0], ten[0], uni[0]}); end
        n_checks++; if (run[0] !== 1'b1) begin n_fail++; $display("FAIL pre_halt_running: got %b expected 1", run[0]); end
        vs_rise();
        dead[0] = 1'b1;
        step();
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h150) begin n_fail++; $display("FAIL dead_on_tick_digits: got %h expected 150", {hun[0], ten[0], uni[0]}); end
        n_checks++; if (run[0] !== 1'b0) begin n_fail++; $display("FAIL dead_on_tick_running: got %b expected 0", run[0]); end
        vs_fall();
        dead[0] = 1'b0;
        ticks(100);
        pulse_start(0);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h150) begin n_fail++; $display("FAIL halt_frozen_digits: got %h expected 150", {hun[0], ten[0], uni[0]}); end
        n_checks++; if (run[0] !== 1'b0) begin n_fail++; $display("FAIL halt_frozen_running: got %b expected 0", run[0]); end
        n_checks++; if (fin[0] !== 1'b0) begin n_fail++; $display("FAIL halt_finished: got %b expected 0", fin[0]); end
        pulse_restart(0);
        n_checks++; if ({hun[0], ten[0], uni[0]} !== 12'h200) begin n_fail++; $display("FAIL halt_restart_digits: got %h expected 200", {hun[0], ten[0], uni[0]}); end
        n_checks++; if (run[0] !== 1'b0) begin n_fail++; $display("FAIL halt_restart_running: got %b expected 0", run[0]); end
        pulse_start(0);
        n_checks++; if (run[0] !== 1'b1) begin n_fail++; $display("FAIL restart_then_start_running: got %b expected 1", run[0]); end
        pulse_restart(0);
    endtask

    task automatic test_finish();
        pulse_start(1);
        tick();
        n_checks++; if ({hun[1], ten[1], uni[1]} !== 12'h001) begin n_fail++; $display("FAIL finish_first_tick: got %h expected 001", {hun[1], ten[1], uni[1]}); end
        n_checks++; if (fin[1] !== 1'b0) begin n_fail++; $display("FAIL finish_early: got %b expected 0", fin[1]); end
        vs_rise();
        step();
        n_checks++; if ({hun[1], ten[1], uni[1]} !== 12'h000) begin n_fail++; $display("FAIL finish_digits: got %h expected 000", {hun[1], ten[1], uni[1]}); end
        n_checks++; if (fin[1] !== 1'b1) begin n_fail++; $display("FAIL finish_same_edge: got %b expected 1", fin[1]); end
        n_checks++; if (run[1] !== 1'b0) begin n_fail++; $display("FAIL finish_running: got %b expected 0", run[1]); end
        n_checks++; if (fp[1] !== 1'b1) begin n_fail++; $display("FAIL finish_pulse_high: got %b expected 1", fp[1]); end
        step();
        n_checks++; if (fp[1] !== 1'b0) begin n_fail++; $display("FAIL finish_pulse_one_cycle: got %b expected 0", fp[1]); end
        vs_fall();
        ticks(5);
        n_checks++; if (fin[1] !== 1'b1) begin n_fail++; $display("FAIL finish_held: got %b expected 1", fin[1]); end
        n_checks++; if ({hun[1], ten[1], uni[1]} !== 12'h000) begin n_fail++; $display("FAIL finish_no_wrap: got %h expected 000", {hun[1], ten[1], uni[1]}); end
        n_checks++; if (fp[1] !== 1'b0) begin n_fail++; $display("FAIL finish_no_repeat_pulse: got %b expected 0", fp[1]); end
    endtask

    task automatic test_restart_vs_tick();
        pulse_start(2);
        ticks(199);
        n_checks++; if ({hun[2], ten[2], uni[2]} !== 12'h001) begin n_fail++; $display("FAIL rvt_pre_digits: got %h expected 001", {hun[2], ten[2], uni[2]}); end
        vs_rise();
        restart[2] = 1'b1;
        step();
        restart[2] = 1'b0;
        n_checks++; if ({hun[2], ten[2], uni[2]} !== 12'h200) begin n_fail++; $display("FAIL rvt_digits: got %h expected 200", {hun[2], ten[2], uni[2]}); end
        n_checks++; if (run[2] !== 1'b0) begin n_fail++; $display("FAIL rvt_running: got %b expected 0", run[2]); end
        n_checks++; if (fin[2] !== 1'b0) begin n_fail++; $display("FAIL rvt_finished: got %b expected 0", fin[2]); end
        n_checks++; if (fp[2] !== 1'b0) begin n_fail++; $display("FAIL rvt_pulse: got %b expected 0", fp[2]); end
        vs_fall();
        n_checks++; if (fp[2] !== 1'b0) begin n_fail++; $display("FAIL rvt_pulse_late: got %b expected 0", fp[2]); end
    endtask

    task automatic test_zero_start();
        pulse_start(3);
        n_checks++; if (fin[3] !== 1'b1) begin n_fail++; $display("FAIL zero_start_finished: got %b expected 1", fin[3]); end
        n_checks++; if (fp[3] !== 1'b1) begin n_fail++; $display("FAIL zero_start_pulse: got %b expected 1", fp[3]); end
        n_checks++; if (run[3] !== 1'b0) begin n_fail++; $display("FAIL zero_start_running: got %b expected 0", run[3]); end
        step();
        n_checks++; if (fp[3] !== 1'b0) begin n_fail++; $display("FAIL zero_start_pulse_width: got %b expected 0", fp[3]); end
    endtask

    task automatic test_async_vsync();
        pulse_start(4);
        for (int f = 0; f < 998; f++) begin
            #($urandom_range(45, 25));
            v_sync = 1'b1;
            #($urandom_range(45, 25));
            v_sync = 1'b0;
        end
        @(posedge clk);
        #1;
        step(); step(); step(); step();
        n_checks++; if ({hun[4], ten[4], uni[4]} !== 12'h001) begin n_fail++; $display("FAIL async_frame_count: got %h expected 001", {hun[4], ten[4], uni[4]}); end
        n_checks++; if (run[4] !== 1'b1) begin n_fail++; $display("FAIL async_running: got %b expected 1", run[4]); end
        tick();
        n_checks++; if ({hun[4], ten[4], uni[4]} !== 12'h000) begin n_fail++; $display("FAIL async_final_digits: got %h expected 000", {hun[4], ten[4], uni[4]}); end
        n_checks++; if (fin[4] !== 1'b1) begin n_fail++; $display("FAIL async_final_finished: got %b expected 1", fin[4]); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_halt();
        test_finish();
        test_restart_vs_tick();
        test_zero_start();
        test_async_vsync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
